// File: rtl/acc_result_writer.sv
// Result writer: buffers finished accumulator results in a small FIFO and
// streams them to the output RAM at consecutive addresses, one job at a time.
module acc_result_writer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_results,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE_S} state_t;

   state_t            state;
   logic [DATA_W-1:0] fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W:0]    count;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] accepted;
   logic [ADDR_W-1:0] written;

   logic full;
   logic empty;
   logic accepting;
   logic push;
   logic pop;

   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign empty     = (count == '0);
   assign accepting = (state == RUN) && (accepted != target);
   assign in_ready  = accepting && !full;
   assign push      = in_valid && in_ready;
   assign mem_we    = (state == RUN) && !empty;
   assign pop       = mem_we && mem_ack;

   // Head is gated so the write bus reads zero whenever no write is requested.
   assign mem_wdata = mem_we ? fifo_mem[rd_ptr] : '0;
   assign mem_addr  = addr;
   assign busy      = (state != IDLE);
   assign done      = (state == DONE_S);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         addr     <= '0;
         target   <= '0;
         accepted <= '0;
         written  <= '0;
         err      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (start) begin
                  addr     <= base_addr;
                  target   <= num_results;
                  accepted <= '0;
                  written  <= '0;
                  err      <= 1'b0;
                  state    <= (num_results == '0) ? DONE_S : RUN;
               end else if (in_valid) begin
                  err <= 1'b1;
               end
            end
            RUN: begin
               if (push) begin
                  accepted <= accepted + ADDR_W'(1);
               end
               if (pop) begin
                  addr    <= addr + ADDR_W'(1);
                  written <= written + ADDR_W'(1);
                  if ((written + ADDR_W'(1)) == target) begin
                     state <= DONE_S;
                  end
               end
               // Backpressure from a full FIFO is not an error; excess results are.
               if (in_valid && !accepting) begin
                  err <= 1'b1;
               end
            end
            DONE_S: begin
               state <= IDLE;
               if (in_valid) begin
                  err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_acc_result_writer.sv
// Scoreboard bench for acc_result_writer: expected RAM writes are queued by the
// stimulus and checked by an independent monitor on every acked write.
module tb_acc_result_writer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] num_results = '0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack = 1'b1;
   logic              busy;
   logic              done;
   logic              err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_ack_cyc = -1;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   wr_t exp_q[$];

   acc_result_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_results(num_results), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .busy(busy), .done(done),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (mem_we && mem_ack) begin
         last_ack_cyc = cyc;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", 64'(mem_addr), 64'(e.a));
            check("wr_data", 64'(mem_wdata), 64'(e.d));
         end
      end
   end

   task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Called and returns at posedge+1.
   task automatic start_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      base_addr   = b;
      num_results = n;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      int t = 0;
      bit ok = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && t < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         else t++;
      end
      if (!ok) check("send_accept", 64'(ok), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input bit chk_lat);
      int t = 0;
      bit seen = 0;
      while (!seen && t < 400) begin
         @(negedge clk);
         if (done) seen = 1;
         else t++;
      end
      check({name, "_done_seen"}, 64'(seen), 64'd1);
      if (seen && chk_lat) check({name, "_done_lat"}, 64'(cyc), 64'(last_ack_cyc + 1));
      @(posedge clk); #1;
      check({name, "_done_clear"}, 64'(done), 64'd0);
      check({name, "_busy_clear"}, 64'(busy), 64'd0);
      check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_in_ready"},  64'(in_ready),  64'd0);
      check({name, "_mem_we"},    64'(mem_we),    64'd0);
      check({name, "_mem_addr"},  64'(mem_addr),  64'd0);
      check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({name, "_busy"},      64'(busy),      64'd0);
      check({name, "_done"},      64'(done),      64'd0);
      check({name, "_err"},       64'(err),       64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      @(posedge clk); #1;

      // 1: four results back-to-back with RAM always acking
      mem_ack = 1'b1;
      expect_wr(10'h010, 32'd1);
      expect_wr(10'h011, 32'd2);
      expect_wr(10'h012, 32'd3);
      expect_wr(10'h013, 32'd4);
      start_job(10'h010, 10'd4);
      check("t1_busy", 64'(busy), 64'd1);
      send(32'd1);
      check("t1_lat_we", 64'(mem_we), 64'd1);
      check("t1_lat_addr", 64'(mem_addr), 64'h010);
      send(32'd2);
      send(32'd3);
      send(32'd4);
      wait_done("t1", 1'b1);

      // 2: twelve results against a stalled RAM
      mem_ack = 1'b0;
      for (int i = 0; i < 12; i++) expect_wr(10'h020 + 10'(i), 32'hA000_0000 + 32'(i));
      start_job(10'h020, 10'd12);
      for (int i = 0; i < 8; i++) send(32'hA000_0000 + 32'(i));
      check("t2_full_ready", 64'(in_ready), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      check("t2_hold_ready", 64'(in_ready), 64'd0);
      check("t2_hold_we", 64'(mem_we), 64'd1);
      check("t2_hold_addr", 64'(mem_addr), 64'h020);
      check("t2_hold_data", 64'(mem_wdata), 64'hA000_0000);
      mem_ack = 1'b1;
      for (int i = 8; i < 12; i++) send(32'hA000_0000 + 32'(i));
      wait_done("t2", 1'b1);

      // 3: address wrap at the top of the RAM
      expect_wr(10'h3FE, 32'h11);
      expect_wr(10'h3FF, 32'h22);
      expect_wr(10'h000, 32'h33);
      expect_wr(10'h001, 32'h44);
      start_job(10'h3FE, 10'd4);
      send(32'h11);
      send(32'h22);
      send(32'h33);
      send(32'h44);
      wait_done("t3", 1'b1);

      // 4: empty job, then a stray result while idle
      start_job(10'h055, 10'd0);
      check("t4_done", 64'(done), 64'd1);
      check("t4_busy", 64'(busy), 64'd1);
      check("t4_no_we", 64'(mem_we), 64'd0);
      @(posedge clk); #1;
      check("t4_done_clear", 64'(done), 64'd0);
      check("t4_idle", 64'(busy), 64'd0);
      check("t4_err_before", 64'(err), 64'd0);
      in_valid = 1'b1;
      in_data  = 32'hDEAD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t4_err_set", 64'(err), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("t4_err_sticky", 64'(err), 64'd1);

      // 5: upstream overruns the result count
      expect_wr(10'h100, 32'hA5);
      expect_wr(10'h101, 32'h5A);
      start_job(10'h100, 10'd2);
      check("t5_err_cleared", 64'(err), 64'd0);
      send(32'hA5);
      send(32'h5A);
      in_valid = 1'b1;
      in_data  = 32'hBAD;
      check("t5_refused", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t5_err", 64'(err), 64'd1);
      wait_done("t5", 1'b1);
      check("t5_err_sticky", 64'(err), 64'd1);

      // 6: reset in the middle of a job with three results queued
      mem_ack = 1'b0;
      start_job(10'h200, 10'd5);
      send(32'hC1);
      send(32'hC2);
      send(32'hC3);
      check("t6_pending_we", 64'(mem_we), 64'd1);
      check("t6_pending_addr", 64'(mem_addr), 64'h200);
      rst = 1'b0;
      #1;
      check_all_zero("t6_rst");
      mem_ack = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_idle_after_rst", 64'(busy), 64'd0);
      expect_wr(10'h050, 32'hB1);
      expect_wr(10'h051, 32'hB2);
      start_job(10'h050, 10'd2);
      send(32'hB1);
      send(32'hB2);
      wait_done("t6", 1'b1);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
